pcpi_serial_bridge: RTL and testbench
=====================================

PCPI_SERIAL_BRIDGE -- requirements
Module: pcpi_serial_bridge

Interface
REQ-001 Parameter SEG_W, default 4: bits per serial segment, in and out.
REQ-002 Parameter XLEN, default 32: PCPI word width; XLEN % SEG_W != 0 SHALL be an elaboration error.
REQ-003 Parameter TIMEOUT_CYC, default 64: coprocessor response timeout in cycles.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 seg_in  input  SEG_W  host segment data.
REQ-007 seg_stb  input  1  host level strobe, segment valid.
REQ-008 seg_ack  output  1  one-cycle pulse, segment accepted.
REQ-009 pcpi_valid  output  1  coprocessor request.
REQ-010 pcpi_insn, pcpi_rs1, pcpi_rs2  output  XLEN each  instruction and operands.
REQ-011 pcpi_ready, pcpi_wr, pcpi_wait  input  1 each  coprocessor handshake.
REQ-012 pcpi_rd  input  XLEN  coprocessor result.
REQ-013 rd_out  output  SEG_W  current result segment.
REQ-014 rd_vld  output  1  rd_out valid.
REQ-015 rd_take  input  1  host consumes rd_out.
REQ-016 busy  output  1  high in any state other than LOAD/WAIT_LOW.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 States: LOAD, ACK, WAIT_LOW, ISSUE, DRAIN.
REQ-019 LOAD with seg_stb=1: write seg_in into segment slot idx, go ACK.
REQ-020 ACK: seg_ack=1 one cycle; idx+1; go WAIT_LOW, or ISSUE with pcpi_valid=1 when idx = 3*XLEN/SEG_W-1 (idx wraps to 0).
REQ-021 WAIT_LOW: return to LOAD only after seg_stb sampled 0; one ack per strobe high phase.
REQ-022 Slot order: insn, rs1, rs2; least-significant segment first within each word.
REQ-023 ISSUE: pcpi_valid held high until pcpi_ready sampled 1; cleared on that edge.
REQ-024 On ready with pcpi_wr=1: capture pcpi_rd, segment count 0, go DRAIN; with pcpi_wr=0: go LOAD.
REQ-025 DRAIN: rd_vld=1, rd_out = captured segment, LSB first; rd_take=1 advances; after XLEN/SEG_W takes go LOAD with rd_vld=0.
REQ-026 seg_stb ignored (no ack, no write) in ISSUE and DRAIN; rd_take ignored outside DRAIN.
REQ-027 pcpi_insn/rs1/rs2 SHALL be stable throughout ISSUE.

Reset
REQ-028 rst_n=0: state LOAD, idx 0, pcpi_valid 0, seg_ack 0, rd_vld 0, busy 0, err 0, rd_out 0; PCPI data registers 0.
REQ-029 Reset mid-load, mid-issue or mid-drain discards partial data; next load starts at slot 0.

Configuration
REQ-030 Macro PCPI_BRIDGE_TIMEOUT_EN defined: in ISSUE a counter increments each cycle with ready=0 and wait=0, clears while wait=1; on reaching TIMEOUT_CYC, pcpi_valid drops, err=1, go LOAD.
REQ-031 pcpi_ready=1 in the expiry cycle SHALL win (normal completion, no err).
REQ-032 err clears on reset or next accepted segment.
REQ-033 Macro undefined: no counter, err tied 0, ISSUE waits indefinitely.

Structure
REQ-034 Package pcpi_bridge_pkg: state enum, slot-order constants, segment-count function.
REQ-035 Sub-module pcpi_seg_deser: segment writer into the three PCPI word registers, indexed by idx.

Verification (SEG_W=4, XLEN=32, TIMEOUT_CYC=64)
REQ-036 24 segments for insn 0x0200_00B3, rs1 0x6, rs2 0x7; ready+wr 3 cycles later, rd 0xDEADBEEF -> pcpi_valid high exactly until ready; rd_out F,E,E,B,D,A,E,D.
REQ-037 Same load, ready with wr=0 -> no rd_vld, busy low next cycle.
REQ-038 TIMEOUT_EN, ready never, wait=0 -> valid drops after 64 cycles, err=1; wait=1 for 200 cycles -> err stays 0.
REQ-039 Reset after 10 segments, then 24 fresh segments -> words contain only fresh data.
REQ-040 seg_stb held high 20 cycles -> exactly one seg_ack, one slot written.
REQ-041 ready asserted in cycle 64 of ISSUE -> normal completion, err=0.

Source files
------------

// File: rtl/pcpi_bridge_pkg.sv
// Shared types and helpers for the serial-to-PCPI bridge: FSM states, word slot order
// and segment-count arithmetic.
package pcpi_bridge_pkg;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_ACK,
      ST_WAIT_LOW,
      ST_ISSUE,
      ST_DRAIN
   } state_e;

   localparam int SLOT_INSN = 0;
   localparam int SLOT_RS1  = 1;
   localparam int SLOT_RS2  = 2;
   localparam int N_SLOTS   = 3;

   function automatic int seg_count(input int xlen, input int seg_w);
      return xlen / seg_w;
   endfunction

endpackage

// File: rtl/pcpi_seg_deser.sv
// Segment writer: places one SEG_W segment into the insn/rs1/rs2 word registers,
// slot-indexed with insn first and the least-significant segment first within each word.
import pcpi_bridge_pkg::*;

module pcpi_seg_deser #(
   parameter int SEG_W = 4,
   parameter int XLEN  = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [SEG_W-1:0] i_seg,
   output logic [XLEN-1:0]  o_insn,
   output logic [XLEN-1:0]  o_rs1,
   output logic [XLEN-1:0]  o_rs2
);

   localparam int NSEG = N_SLOTS * seg_count(XLEN, SEG_W);

   // Flat image of all three words; slot k occupies bits [k*SEG_W +: SEG_W].
   logic [N_SLOTS*XLEN-1:0] r_words;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_words <= '0;
      end else if (i_wr) begin
         for (int s = 0; s < NSEG; s++) begin
            if (i_idx == IDX_W'(s)) r_words[s*SEG_W +: SEG_W] <= i_seg;
         end
      end
   end

   assign o_insn = r_words[SLOT_INSN*XLEN +: XLEN];
   assign o_rs1  = r_words[SLOT_RS1*XLEN  +: XLEN];
   assign o_rs2  = r_words[SLOT_RS2*XLEN  +: XLEN];

endmodule

// File: rtl/pcpi_serial_bridge.sv
// Serial segment host to PCPI coprocessor bridge. Optional issue timeout is built when
// PCPI_BRIDGE_TIMEOUT_EN is defined.
//
//   state    | meaning
//   LOAD     | idle, waiting for a host segment strobe
//   ACK      | segment written, seg_ack pulsed
//   WAIT_LOW | waiting for the host to drop seg_stb
//   ISSUE    | pcpi_valid high, waiting for pcpi_ready
//   DRAIN    | streaming the captured result out LSB segment first
import pcpi_bridge_pkg::*;

module pcpi_serial_bridge #(
   parameter int SEG_W       = 4,
   parameter int XLEN        = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEG_W-1:0] seg_in,
   input  logic             seg_stb,
   output logic             seg_ack,
   output logic             pcpi_valid,
   output logic [XLEN-1:0]  pcpi_insn,
   output logic [XLEN-1:0]  pcpi_rs1,
   output logic [XLEN-1:0]  pcpi_rs2,
   input  logic             pcpi_ready,
   input  logic             pcpi_wr,
   input  logic             pcpi_wait,
   input  logic [XLEN-1:0]  pcpi_rd,
   output logic [SEG_W-1:0] rd_out,
   output logic             rd_vld,
   input  logic             rd_take,
   output logic             busy,
   output logic             err
);

   localparam int NWSEG = seg_count(XLEN, SEG_W);
   localparam int NSEG  = N_SLOTS * NWSEG;
   localparam int IDX_W = $clog2(NSEG);
   localparam int RC_W  = $clog2(NWSEG + 1);

   generate
      if (XLEN % SEG_W != 0) begin : g_bad_width
         $error("pcpi_serial_bridge: XLEN must be a multiple of SEG_W");
      end
   endgenerate

   state_e            r_state;
   state_e            w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [XLEN-1:0]   r_rd;
   logic [RC_W-1:0]   r_rcnt;
   logic              w_seg_wr;
   logic              w_last_seg;
   logic              w_last_take;
   logic              w_capture;
   logic              w_take;
   logic              w_to_expire;

   assign w_last_seg  = (r_idx == IDX_W'(NSEG - 1));
   assign w_last_take = (r_rcnt == RC_W'(NWSEG - 1));
   assign w_capture   = (r_state == ST_ISSUE) && pcpi_ready && pcpi_wr;
   assign w_take      = (r_state == ST_DRAIN) && rd_take;

   always_comb begin
      w_state_nxt = r_state;
      w_seg_wr    = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (seg_stb) begin
               w_seg_wr    = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK:      w_state_nxt = w_last_seg ? ST_ISSUE : ST_WAIT_LOW;
         ST_WAIT_LOW: if (!seg_stb) w_state_nxt = ST_LOAD;
         ST_ISSUE: begin
            if (pcpi_ready)       w_state_nxt = pcpi_wr ? ST_DRAIN : ST_LOAD;
            else if (w_to_expire) w_state_nxt = ST_LOAD;
         end
         ST_DRAIN:    if (w_take && w_last_take) w_state_nxt = ST_LOAD;
         default:     w_state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_LOAD;
         r_idx   <= '0;
         r_rd    <= '0;
         r_rcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_ACK) r_idx <= w_last_seg ? '0 : r_idx + 1'b1;
         if (w_capture) begin
            r_rd   <= pcpi_rd;
            r_rcnt <= '0;
         end else if (w_take) begin
            r_rd   <= r_rd >> SEG_W;
            r_rcnt <= r_rcnt + 1'b1;
         end
      end
   end

`ifdef PCPI_BRIDGE_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_err;

   // Ready in the expiry cycle wins because the state mux tests pcpi_ready first.
   assign w_to_expire = (r_state == ST_ISSUE) && !pcpi_ready && !pcpi_wait &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state != ST_ISSUE || pcpi_wait || pcpi_ready) r_to_cnt <= '0;
         else                                                r_to_cnt <= r_to_cnt + 1'b1;
         if (w_to_expire)   r_err <= 1'b1;
         else if (w_seg_wr) r_err <= 1'b0;
      end
   end

   assign err = r_err;
`else
   // Without the timeout, pcpi_wait has no effect and ISSUE waits indefinitely.
   assign w_to_expire = pcpi_wait & 1'b0;
   assign err         = 1'b0;
`endif

   pcpi_seg_deser #(
      .SEG_W (SEG_W),
      .XLEN  (XLEN),
      .IDX_W (IDX_W)
   ) u_deser (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_wr   (w_seg_wr),
      .i_idx  (r_idx),
      .i_seg  (seg_in),
      .o_insn (pcpi_insn),
      .o_rs1  (pcpi_rs1),
      .o_rs2  (pcpi_rs2)
   );

   assign seg_ack    = (r_state == ST_ACK);
   assign pcpi_valid = (r_state == ST_ISSUE);
   assign rd_vld     = (r_state == ST_DRAIN);
   assign rd_out     = (r_state == ST_DRAIN) ? r_rd[SEG_W-1:0] : '0;
   assign busy       = !(r_state == ST_LOAD || r_state == ST_WAIT_LOW);

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// Directed bench for pcpi_serial_bridge with a per-cycle behavioural model plus literal checks.
module tb_pcpi_serial_bridge;

   localparam int SEG_W  = 4;
   localparam int XLEN   = 32;
   localparam int TO_CYC = 64;
   localparam int NW     = XLEN / SEG_W;
   localparam int NS     = 3 * NW;
`ifdef PCPI_BRIDGE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic [SEG_W-1:0] seg_in;
   logic             seg_stb;
   logic             seg_ack;
   logic             pcpi_valid;
   logic [XLEN-1:0]  pcpi_insn;
   logic [XLEN-1:0]  pcpi_rs1;
   logic [XLEN-1:0]  pcpi_rs2;
   logic             pcpi_ready;
   logic             pcpi_wr;
   logic             pcpi_wait;
   logic [XLEN-1:0]  pcpi_rd;
   logic [SEG_W-1:0] rd_out;
   logic             rd_vld;
   logic             rd_take;
   logic             busy;
   logic             err;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic [3:0] got [8];
   localparam logic [3:0] EXP_SEQ [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};

   pcpi_serial_bridge #(
      .SEG_W       (SEG_W),
      .XLEN        (XLEN),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_in     (seg_in),
      .seg_stb    (seg_stb),
      .seg_ack    (seg_ack),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_rs1   (pcpi_rs1),
      .pcpi_rs2   (pcpi_rs2),
      .pcpi_ready (pcpi_ready),
      .pcpi_wr    (pcpi_wr),
      .pcpi_wait  (pcpi_wait),
      .pcpi_rd    (pcpi_rd),
      .rd_out     (rd_out),
      .rd_vld     (rd_vld),
      .rd_take    (rd_take),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: tracks what the host and coprocessor have done so far.
   bit          e_ack, e_need_low, e_issue, e_err;
   int          e_nseg, e_age, e_left;
   logic [31:0] e_rd;
   logic [31:0] e_w [3];

   always @(posedge clk) begin
      if (!rst_n) begin
         e_ack = 0; e_need_low = 0; e_issue = 0; e_err = 0;
         e_nseg = 0; e_age = 0; e_left = 0; e_rd = '0;
         for (int i = 0; i < 3; i++) e_w[i] = '0;
      end else if (e_ack) begin
         e_ack = 0;
         if (e_nseg == NS) begin
            e_nseg = 0; e_issue = 1; e_age = 0;
         end else begin
            e_need_low = 1;
         end
      end else if (e_issue) begin
         if (pcpi_ready) begin
            e_issue = 0;
            if (pcpi_wr) begin
               e_left = NW; e_rd = pcpi_rd;
            end
         end else if (TO_EN) begin
            if (pcpi_wait) e_age = 0;
            else begin
               e_age++;
               if (e_age == TO_CYC) begin
                  e_issue = 0; e_err = 1;
               end
            end
         end
      end else if (e_left > 0) begin
         if (rd_take) e_left--;
      end else if (e_need_low) begin
         if (!seg_stb) e_need_low = 0;
      end else if (seg_stb) begin
         e_w[e_nseg / NW][SEG_W*(e_nseg % NW) +: SEG_W] = seg_in;
         e_nseg++; e_ack = 1; e_err = 0;
      end
   end

   function automatic logic [31:0] exp_rd_out();
      if (e_left > 0) return (e_rd >> (SEG_W * (NW - e_left))) & 32'hF;
      return 32'h0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("seg_ack", {31'b0, seg_ack}, {31'b0, e_ack});
         check("pcpi_valid", {31'b0, pcpi_valid}, {31'b0, e_issue});
         check("rd_vld", {31'b0, rd_vld}, {31'b0, e_left > 0});
         check("busy", {31'b0, busy}, {31'b0, e_ack || e_issue || e_left > 0});
         check("err", {31'b0, err}, {31'b0, e_err});
         check("rd_out", {28'b0, rd_out}, exp_rd_out());
         check("pcpi_insn", pcpi_insn, e_w[0]);
         check("pcpi_rs1", pcpi_rs1, e_w[1]);
         check("pcpi_rs2", pcpi_rs2, e_w[2]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] seg_of(input int k, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
      logic [95:0] all;
      all = {c, b, a};
      return all[4*k +: 4];
   endfunction

   task automatic send_seg(input logic [3:0] v);
      int n;
      n = 0;
      seg_in  = v;
      seg_stb = 1'b1;
      do begin
         step();
         n++;
      end while (!seg_ack && n < 10);
      check("seg_ack_wait", {31'b0, seg_ack}, 32'h1);
      seg_stb = 1'b0;
   endtask

   // Returns in ACK after the final slot; otherwise returns back in LOAD.
   task automatic load_range(input int first, input int last, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
      for (int k = first; k <= last; k++) begin
         send_seg(seg_of(k, a, b, c));
         if (k != NS - 1) begin
            step();
            step();
         end
      end
   endtask

   task automatic drain(output logic [31:0] word);
      word = '0;
      for (int i = 0; i < NW; i++) begin
         if (i == 3) begin
            rd_take = 1'b0;
            step();
         end
         got[i] = rd_out;
         word[4*i +: 4] = rd_out;
         rd_take = 1'b1;
         step();
      end
      rd_take = 1'b0;
   endtask

   task automatic finish_no_wr();
      pcpi_ready = 1'b1;
      pcpi_wr    = 1'b0;
      step();
      pcpi_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      int cnt;
      rst_n = 1'b0; seg_in = '0; seg_stb = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0;
      pcpi_wait = 1'b0; pcpi_rd = '0; rd_take = 1'b0;
      repeat (3) step();
      chk_en = 1'b1;
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_valid", {31'b0, pcpi_valid}, 32'h0);
      check("rst_rd_out", {28'b0, rd_out}, 32'h0);
      check("rst_insn", pcpi_insn, 32'h0);
      rst_n = 1'b1;
      step();

      // Full load, ready+wr three cycles into ISSUE, drain 0xDEADBEEF
      load_range(0, NS - 1, 32'h0200_00B3, 32'h6, 32'h7);
      check("lit_insn", pcpi_insn, 32'h0200_00B3);
      check("lit_rs1", pcpi_rs1, 32'h6);
      check("lit_rs2", pcpi_rs2, 32'h7);
      cnt = 0;
      repeat (3) begin
         step();
         if (pcpi_valid) cnt++;
      end
      check("lit_valid_cycles", cnt, 3);
      pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEAD_BEEF;
      step();
      pcpi_ready = 1'b0; pcpi_wr = 1'b0;
      check("lit_valid_dropped", {31'b0, pcpi_valid}, 32'h0);
      check("lit_rd_vld", {31'b0, rd_vld}, 32'h1);
      drain(w);
      for (int i = 0; i < NW; i++) check("lit_rd_seq", {28'b0, got[i]}, {28'b0, EXP_SEQ[i]});
      check("lit_drain_done", {31'b0, rd_vld}, 32'h0);

      // Same load, completion without a result
      load_range(0, NS - 1, 32'h0200_00B3, 32'h6, 32'h7);
      step();
      finish_no_wr();
      check("lit_nowr_busy", {31'b0, busy}, 32'h0);
      check("lit_nowr_rd_vld", {31'b0, rd_vld}, 32'h0);

      // Strobe held high: one ack, one slot
      seg_in = 4'hA; seg_stb = 1'b1; cnt = 0;
      repeat (20) begin
         step();
         if (seg_ack) cnt++;
      end
      seg_stb = 1'b0;
      step(); step();
      check("lit_held_acks", cnt, 1);
      check("lit_held_insn", pcpi_insn, 32'h0200_00BA);

      // Ten segments total, reset, then a fresh load
      load_range(1, 9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("lit_rst_insn", pcpi_insn, 32'h0);
      check("lit_rst_rs1", pcpi_rs1, 32'h0);
      check("lit_rst_busy", {31'b0, busy}, 32'h0);
      step();
      load_range(0, NS - 1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C);
      check("lit_fresh_insn", pcpi_insn, 32'h1234_5678);
      check("lit_fresh_rs1", pcpi_rs1, 32'h9ABC_DEF0);
      check("lit_fresh_rs2", pcpi_rs2, 32'h0F1E_2D3C);
      step();
      finish_no_wr();

`ifdef PCPI_BRIDGE_TIMEOUT_EN
      load_range(0, NS - 1, 32'h1, 32'h2, 32'h3);
      cnt = 0;
      step();
      while (pcpi_valid && cnt < 100) begin
         cnt++;
         step();
      end
      check("lit_timeout_cycles", cnt, TO_CYC);
      check("lit_timeout_err", {31'b0, err}, 32'h1);

      load_range(0, NS - 1, 32'h4, 32'h5, 32'h6);
      pcpi_wait = 1'b1;
      repeat (200) step();
      check("lit_wait_valid", {31'b0, pcpi_valid}, 32'h1);
      check("lit_wait_err", {31'b0, err}, 32'h0);
      pcpi_wait = 1'b0;
      finish_no_wr();

      load_range(0, NS - 1, 32'h7, 32'h8, 32'h9);
      repeat (TO_CYC) step();
      pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h1357_9BDF;
      step();
      pcpi_ready = 1'b0; pcpi_wr = 1'b0;
      check("lit_race_rd_vld", {31'b0, rd_vld}, 32'h1);
      check("lit_race_err", {31'b0, err}, 32'h0);
      drain(w);
      check("lit_race_word", w, 32'h1357_9BDF);
`else
      load_range(0, NS - 1, 32'h1, 32'h2, 32'h3);
      repeat (150) step();
      check("lit_nto_valid", {31'b0, pcpi_valid}, 32'h1);
      check("lit_nto_err", {31'b0, err}, 32'h0);
      finish_no_wr();
`endif
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
